// File: rtl/vga_sync_receiver.sv
// Receive side of a VGA timing interface: measures line/frame geometry from HS/VS/blank,
// declares lock once two consecutive frames agree, and recovers visible pixel coordinates.
module vga_sync_receiver #(
    parameter logic        SPP = 1'b0,
    parameter int unsigned CW  = 11,
    parameter int unsigned TMO = 2047
) (
    input  logic          pixel_clk,
    input  logic          rst_n,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          blank_in,
    output logic          locked,
    output logic          lock_lost,
    output logic          frame_start,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_active,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          pix_valid
);

    localparam logic [CW-1:0] TmoVal = CW'(TMO);
    localparam logic [CW-1:0] MaxVal = '1;
    localparam logic [CW-1:0] One    = CW'(1);

    typedef enum logic [1:0] {StSearch, StMeasure, StVerify, StLocked} state_e;

    state_e        state_q, state_d;
    logic          hs_q, vs_q, blank_q, hs_prev_q, vs_prev_q;
    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d, ac_q, ac_d, fc_q, fc_d;
    logic [CW-1:0] last_period_q, last_period_d;
    logic [CW-1:0] cand_h_q, cand_h_d, cand_v_q, cand_v_d;
    logic [CW-1:0] h_active_q, h_active_d, v_active_q, v_active_d;
    logic [CW-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic          locked_q, lock_lost_q, frame_start_q, pix_valid_q;

    logic          hs_edge, vs_edge, nb, line_active, timeout, lost, lock_d;
    logic [CW-1:0] period, vc_base, fc_inc, x_now;

    assign hs_edge     = (hs_prev_q != SPP) && (hs_q == SPP);
    assign vs_edge     = (vs_prev_q != SPP) && (vs_q == SPP);
    assign nb          = ~blank_q;
    assign line_active = hs_edge && (ac_q != '0);
    // A coincident HS edge closes the previous line, so its pre-clear count is the period.
    assign period      = hs_edge ? hc_q : last_period_q;
    assign timeout     = (hc_q == TmoVal) || (vc_q == TmoVal);

    always_comb begin
        state_d  = state_q;
        cand_h_d = cand_h_q;
        cand_v_d = cand_v_q;
        lost     = 1'b0;
        case (state_q)
            StSearch: begin
                if (vs_edge) state_d = StMeasure;
            end
            StMeasure: begin
                if (timeout) begin
                    state_d = StSearch;
                end else if (vs_edge) begin
                    cand_h_d = period;
                    cand_v_d = vc_q;
                    state_d  = StVerify;
                end
            end
            StVerify: begin
                if (timeout) begin
                    state_d = StSearch;
                end else if (vs_edge) begin
                    if (period == cand_h_q && vc_q == cand_v_q) begin
                        state_d = StLocked;
                    end else begin
                        cand_h_d = period;
                        cand_v_d = vc_q;
                    end
                end
            end
            StLocked: begin
                if (timeout || (hs_edge && hc_q != cand_h_q) || (vs_edge && vc_q != cand_v_q)) begin
                    state_d = StSearch;
                    lost    = 1'b1;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_comb begin
        hc_d          = hs_edge ? One : ((hc_q == TmoVal) ? hc_q : hc_q + One);
        // VS clears before the HS increment when both edges land together.
        vc_base       = vs_edge ? '0 : vc_q;
        vc_d          = (hs_edge && vc_base != TmoVal) ? vc_base + One : vc_base;
        ac_d          = hs_edge ? CW'(nb) : ((ac_q == MaxVal) ? ac_q : ac_q + CW'(nb));
        fc_inc        = (line_active && fc_q != MaxVal) ? fc_q + One : fc_q;
        fc_d          = vs_edge ? '0 : fc_inc;
        last_period_d = period;
        h_active_d    = line_active ? ac_q : h_active_q;
        v_active_d    = vs_edge ? fc_inc : v_active_q;
        lock_d        = (state_d == StLocked);
        x_now         = hs_edge ? '0 : ac_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        if (!lock_d) begin
            pixel_x_d = '0;
            pixel_y_d = '0;
        end else if (nb) begin
            pixel_x_d = x_now;
            pixel_y_d = fc_d;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StSearch;
            hs_q          <= ~SPP;
            vs_q          <= ~SPP;
            blank_q       <= 1'b1;
            hs_prev_q     <= ~SPP;
            vs_prev_q     <= ~SPP;
            hc_q          <= '0;
            vc_q          <= '0;
            ac_q          <= '0;
            fc_q          <= '0;
            last_period_q <= '0;
            cand_h_q      <= '0;
            cand_v_q      <= '0;
            h_active_q    <= '0;
            v_active_q    <= '0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            locked_q      <= 1'b0;
            lock_lost_q   <= 1'b0;
            frame_start_q <= 1'b0;
            pix_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_in;
            vs_q          <= vs_in;
            blank_q       <= blank_in;
            hs_prev_q     <= hs_q;
            vs_prev_q     <= vs_q;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            ac_q          <= ac_d;
            fc_q          <= fc_d;
            last_period_q <= last_period_d;
            cand_h_q      <= cand_h_d;
            cand_v_q      <= cand_v_d;
            h_active_q    <= h_active_d;
            v_active_q    <= v_active_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            locked_q      <= lock_d;
            lock_lost_q   <= lost;
            frame_start_q <= vs_edge;
            pix_valid_q   <= lock_d && nb;
        end
    end

    assign locked      = locked_q;
    assign lock_lost   = lock_lost_q;
    assign frame_start = frame_start_q;
    assign h_total     = cand_h_q;
    assign v_total     = cand_v_q;
    assign h_active    = h_active_q;
    assign v_active    = v_active_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign pix_valid   = pix_valid_q;

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive end of the VGA timing interface: consumes HS, VS and blank from a timing source and recovers per-pixel coordinates.
- Measures line and frame geometry and declares lock once the timing is stable.
- Sits between any VGA-style timing source (local generator or external capture) and downstream pixel consumers: frame grabber, overlay checker, timing monitor.

Parameters:
- SPP, 0, sync pulse polarity: value HS/VS take during the pulse; the leading edge is the transition into SPP.
- CW, 11, width of all counters and measured values.
- TMO, 2047, timeout limit for both the per-line clock count and the per-frame line count; must be ≤ 2^CW-1.

Ports:
- pixel_clk  in  1  pixel clock; all inputs synchronous to it
- rst_n  in  1  asynchronous active-low reset
- hs_in  in  1  horizontal sync
- vs_in  in  1  vertical sync
- blank_in  in  1  1 = non-visible pixel
- locked  out  1  timing stable
- lock_lost  out  1  one-cycle pulse on LOCKED→SEARCH
- frame_start  out  1  one-cycle pulse per VS leading edge
- h_total  out  CW  clocks between consecutive HS leading edges
- v_total  out  CW  HS leading edges between consecutive VS leading edges
- h_active  out  CW  non-blank clocks in the last line that had any
- v_active  out  CW  lines with ≥1 non-blank clock in the previous frame
- pixel_x  out  CW  column of the current visible pixel
- pixel_y  out  CW  row of the current visible pixel
- pix_valid  out  1  pixel_x/pixel_y valid (visible and locked)

Behaviour:
- Reset (async assert, sync-released flops): every output 0; FSM in SEARCH; all counters 0; input registers load inactive sync (~SPP) and blank=1.
- Input stage: hs/vs/blank registered once. Edge detect compares the registered value with its previous value. A leading edge is prev≠SPP and cur==SPP.
- All outputs are registered. Latency from an input change to the corresponding output (frame_start, pix_valid, pixel_x) is exactly 2 pixel_clk cycles.
- Line counter hc:
  - Cleared to 1 on an HS leading edge, otherwise incremented.
  - Saturates at TMO.
  - At an HS leading edge, the pre-clear value is the measured line period.
- Line count vc:
  - Cleared to 0 on a VS leading edge, incremented on each HS leading edge.
  - Saturates at TMO.
  - When HS and VS leading edges coincide, the VS clear occurs first, then the HS increment, giving vc=1.
- Active counter ac:
  - Counts non-blank clocks since the last HS edge.
  - At an HS edge, if ac≠0: h_active←ac and the line-had-active flag is set.
  - v_active←number of flagged lines, captured at each VS edge.
- FSM:
  - SEARCH: go to MEASURE on a VS edge.
  - MEASURE: on the next VS edge, capture the candidate h_total (last line period) and v_total (vc), then go to VERIFY.
  - VERIFY: on the next VS edge, compare both values with the candidate.
    - Equal: go to LOCKED; locked=1.
    - Different: store the new candidate and stay in VERIFY.
  - LOCKED:
    - Every HS edge compares the line period with h_total; every VS edge compares vc with v_total.
    - Any mismatch, or hc or vc reaching TMO, forces SEARCH with locked=0 and a lock_lost pulse.
    - In SEARCH, pixel outputs are held: pixel_x=pixel_y=0, pix_valid=0.
  - Timeout in MEASURE or VERIFY returns to SEARCH without a lock_lost pulse.
- Pixel coordinates:
  - pixel_x is 0 on the first non-blank clock after an HS edge and +1 on each subsequent non-blank clock.
  - pixel_y is 0 on the first active line after a VS edge and +1 at each HS edge that ends a flagged line.
  - pix_valid = registered ~blank AND locked.
  - Both coordinates are held while blank and saturate at 2^CW-1.
- frame_start pulses in every state, including SEARCH.
- Reset mid-frame: all state is lost and lock must be reacquired from SEARCH.

Test Plan:
- Clean stream (line period 800, 525 lines, 640×480 visible, HS pulse clocks 648–743, VS pulse lines 482–483, SPP=0) from reset → locked rises 2 cycles after the 3rd VS leading edge. Then h_total=800, v_total=525, h_active=640, v_active=480.
- While locked → pixel_x runs 0..639 with pix_valid on each visible line; pixel_y runs 0..479; first pixel_x=0 appears 2 cycles after blank falls; frame_start once per frame.
- Locked, one line shortened to 799 clocks → lock_lost pulse 2 cycles after that HS edge; locked=0, pix_valid=0; lock regained after 3 further clean VS edges.
- Locked, HS held inactive → hc hits 2047, then locked=0 with lock_lost pulse; no pixel outputs until relock.
- Assert rst_n low mid-line while locked → all outputs 0 immediately (async); after release, locked stays 0 until the 3rd VS edge.
- SPP=1 with inverted syncs of the first scenario → identical measured values and lock timing.
